// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt arbiter slice.
//  - state_t   : handshake FSM encoding (IDLE=0, REQ=1, SERVICE=2); it is
//                exposed through the STATUS register, so the values are fixed.
//  - REG_*     : device register offsets (bus addr[3:2]).
//  - *_DEF     : default source count and id width.
package irq_pkg;

  localparam int N_SRC_DEF = 6;
  localparam int ID_W_DEF  = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  localparam logic [1:0] REG_MASK    = 2'd0;
  localparam logic [1:0] REG_PENDING = 2'd1;
  localparam logic [1:0] REG_ID      = 2'd2;
  localparam logic [1:0] REG_STATUS  = 2'd3;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder.
// Ports:
//  req   in   N_SRC  request vector, bit 0 has the highest priority
//  id    out  ID_W   index of the lowest set bit (0 when nothing is set)
//  valid out  1      at least one request bit is set
module irq_prio_enc #(
  parameter int N_SRC = 6,
  parameter int ID_W  = 3
) (
  input  logic [N_SRC-1:0] req,
  output logic [ID_W-1:0]  id,
  output logic             valid
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    id    = '0;
    valid = 1'b0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        id    = ID_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_arbiter.sv
// Interrupt arbiter: latches rising edges of the device lines as sticky
// pending bits, picks the highest-priority unmasked one and runs the
// request / acknowledge / eret handshake with the controller. State is
// visible and writable through a small four-register device window.
// Ports:
//  clk        in   1      system clock
//  reset      in   1      asynchronous, active-low; clears all state
//  irq_in     in   N_SRC  device interrupt lines, rising edge significant
//  cpu_ie     in   1      CPU global interrupt enable
//  int_ack    in   1      controller is in interrupt entry (1-cycle pulse)
//  int_done   in   1      eret executed (1-cycle pulse)
//  intreq     out  1      registered interrupt request to controller
//  irq_id     out  ID_W   id of the source in service
//  in_service out  1      a source is acknowledged and not yet returned
//  dev_addr   in   2      register select: 0 MASK, 1 PENDING, 2 ID, 3 STATUS
//  dev_we     in   1      register write strobe
//  dev_wdata  in   32     write data
//  dev_rdata  out  32     read data, combinational from dev_addr
module irq_arbiter
  import irq_pkg::*;
#(
  parameter int N_SRC = N_SRC_DEF,
  parameter int ID_W  = ID_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] irq_in,
  input  logic             cpu_ie,
  input  logic             int_ack,
  input  logic             int_done,
  output logic             intreq,
  output logic [ID_W-1:0]  irq_id,
  output logic             in_service,
  input  logic [1:0]       dev_addr,
  input  logic             dev_we,
  input  logic [31:0]      dev_wdata,
  output logic [31:0]      dev_rdata
);

  state_t           state_reg, state_next;
  logic             intreq_reg;
  logic             in_service_reg, in_service_next;
  logic [ID_W-1:0]  irq_id_reg, irq_id_next;
  logic [N_SRC-1:0] mask_reg, mask_next;
  logic [N_SRC-1:0] pending_reg, pending_next;
  logic [N_SRC-1:0] irq_q_reg;

  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] req_vec;
  logic [N_SRC-1:0] ack_clr;
  logic [N_SRC-1:0] w1c;
  logic [ID_W-1:0]  winner_id;
  logic             winner_valid;

  // Only the low N_SRC write-data bits map to register fields.
  logic unused_wdata;
  assign unused_wdata = &{1'b0, dev_wdata[31:N_SRC]};

  assign rise    = irq_in & ~irq_q_reg;
  assign req_vec = pending_reg & mask_reg;

  irq_prio_enc #(
    .N_SRC (N_SRC),
    .ID_W  (ID_W)
  ) u_prio_enc (
    .req   (req_vec),
    .id    (winner_id),
    .valid (winner_valid)
  );

  // Handshake FSM next state. The winner used at acknowledge comes from the
  // registered req_vec, so a source arriving in the ack cycle only becomes
  // pending and never preempts.
  always_comb begin
    state_next      = state_reg;
    in_service_next = in_service_reg;
    irq_id_next     = irq_id_reg;
    ack_clr         = '0;
    case (state_reg)
      ST_IDLE: begin
        if (cpu_ie && (|req_vec)) begin
          state_next = ST_REQ;
        end
      end
      ST_REQ: begin
        // cpu_ie is deliberately not consulted here: the controller gates
        // the request itself, only an empty req_vec withdraws it.
        if (int_ack) begin
          irq_id_next     = winner_id;
          in_service_next = 1'b1;
          state_next      = ST_SERVICE;
          if (winner_valid) begin
            ack_clr = N_SRC'(1) << winner_id;
          end
        end else if (!(|req_vec)) begin
          state_next = ST_IDLE;
        end
      end
      ST_SERVICE: begin
        if (int_done) begin
          in_service_next = 1'b0;
          state_next      = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Pending update: clears (software W1C and acknowledge) are applied first
  // and a fresh rising edge is OR-ed in last, so a new edge always survives.
  always_comb begin
    w1c       = '0;
    mask_next = mask_reg;
    if (dev_we && (dev_addr == REG_PENDING)) begin
      w1c = dev_wdata[N_SRC-1:0];
    end
    if (dev_we && (dev_addr == REG_MASK)) begin
      mask_next = dev_wdata[N_SRC-1:0];
    end
    pending_next = (pending_reg & ~(w1c | ack_clr)) | rise;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= ST_IDLE;
      intreq_reg     <= 1'b0;
      in_service_reg <= 1'b0;
      irq_id_reg     <= '0;
      mask_reg       <= '0;
      pending_reg    <= '0;
      irq_q_reg      <= '0;
    end else begin
      state_reg      <= state_next;
      // Registered alongside the state so intreq is a clean flop output.
      intreq_reg     <= (state_next == ST_REQ);
      in_service_reg <= in_service_next;
      irq_id_reg     <= irq_id_next;
      mask_reg       <= mask_next;
      pending_reg    <= pending_next;
      irq_q_reg      <= irq_in;
    end
  end

  always_comb begin
    dev_rdata = '0;
    case (dev_addr)
      REG_MASK:    dev_rdata[N_SRC-1:0] = mask_reg;
      REG_PENDING: dev_rdata[N_SRC-1:0] = pending_reg;
      REG_ID:      dev_rdata[ID_W:0]    = {in_service_reg, irq_id_reg};
      REG_STATUS:  dev_rdata[2:0]       = {state_reg, intreq_reg};
      default:     dev_rdata            = '0;
    endcase
  end

  assign intreq     = intreq_reg;
  assign irq_id     = irq_id_reg;
  assign in_service = in_service_reg;

endmodule

// File: tb/tb_irq_arbiter.sv
// Self-checking bench for irq_arbiter: directed scenario tasks followed by a
// randomized run checked against a cycle-level behavioural model.
module tb_irq_arbiter;

  localparam int N  = 6;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [N-1:0]  irq_in = '0;
  logic          cpu_ie = 1'b0;
  logic          int_ack = 1'b0;
  logic          int_done = 1'b0;
  logic          intreq;
  logic [IW-1:0] irq_id;
  logic          in_service;
  logic [1:0]    dev_addr = 2'd0;
  logic          dev_we = 1'b0;
  logic [31:0]   dev_wdata = '0;
  logic [31:0]   dev_rdata;

  int n_checks = 0;
  int n_fail = 0;

  irq_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .irq_in     (irq_in),
    .cpu_ie     (cpu_ie),
    .int_ack    (int_ack),
    .int_done   (int_done),
    .intreq     (intreq),
    .irq_id     (irq_id),
    .in_service (in_service),
    .dev_addr   (dev_addr),
    .dev_we     (dev_we),
    .dev_wdata  (dev_wdata),
    .dev_rdata  (dev_rdata)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    dev_addr = a;
    #1;
    d = dev_rdata;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    dev_addr  = a;
    dev_wdata = d;
    dev_we    = 1'b1;
    tick();
    dev_we    = 1'b0;
  endtask

  task automatic pulse_ack();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
  endtask

  task automatic pulse_done();
    int_done = 1'b1;
    tick();
    int_done = 1'b0;
  endtask

  task automatic apply_reset();
    reset    = 1'b0;
    irq_in   = '0;
    cpu_ie   = 1'b0;
    int_ack  = 1'b0;
    int_done = 1'b0;
    dev_we   = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    logic [31:0] d;
    apply_reset();
    n_checks++;
    if (intreq !== 1'b0 || in_service !== 1'b0 || irq_id !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: intreq=%b in_service=%b irq_id=%0d, want 0 0 0", intreq, in_service, irq_id);
    end
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), d);
      n_checks++;
      if (d !== 32'd0) begin
        n_fail++;
        $display("FAIL reset_reg%0d: got 0x%08h want 0x00000000", a, d);
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    logic [31:0] d;
    apply_reset();
    wr(2'd0, 32'h3F);
    cpu_ie = 1'b1;
    irq_in[2] = 1'b1;
    tick();
    irq_in = '0;
    n_checks++;
    if (intreq !== 1'b0) begin n_fail++; $display("FAIL basic_intreq_k: got %b want 0", intreq); end
    tick();
    n_checks++;
    if (intreq !== 1'b1) begin n_fail++; $display("FAIL basic_intreq_k1: got %b want 1", intreq); end
    pulse_ack();
    rd(2'd1, d);
    n_checks++;
    if (irq_id !== 3'd2 || in_service !== 1'b1 || intreq !== 1'b0 || d !== 32'd0) begin
      n_fail++;
      $display("FAIL basic_ack: id=%0d insvc=%b intreq=%b pend=0x%0h, want 2 1 0 0x0", irq_id, in_service, intreq, d);
    end
    pulse_done();
    n_checks++;
    if (in_service !== 1'b0 || intreq !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done: insvc=%b intreq=%b, want 0 0", in_service, intreq);
    end
    tick();
    n_checks++;
    if (intreq !== 1'b0) begin n_fail++; $display("FAIL basic_idle_after: intreq=%b want 0", intreq); end
    $display("test_basic done");
  endtask

  task automatic test_simultaneous();
    logic [31:0] d;
    apply_reset();
    wr(2'd0, 32'h3F);
    cpu_ie = 1'b1;
    irq_in = 6'b010010;
    tick();
    irq_in = '0;
    tick();
    pulse_ack();
    rd(2'd1, d);
    n_checks++;
    if (irq_id !== 3'd1 || d !== 32'h10) begin
      n_fail++;
      $display("FAIL simul_first: id=%0d pend=0x%0h, want 1 0x10", irq_id, d);
    end
    pulse_done();
    n_checks++;
    if (intreq !== 1'b0) begin n_fail++; $display("FAIL simul_gap: intreq=%b want 0", intreq); end
    tick();
    n_checks++;
    if (intreq !== 1'b1) begin n_fail++; $display("FAIL simul_rereq: intreq=%b want 1", intreq); end
    pulse_ack();
    n_checks++;
    if (irq_id !== 3'd4 || in_service !== 1'b1) begin
      n_fail++;
      $display("FAIL simul_second: id=%0d insvc=%b, want 4 1", irq_id, in_service);
    end
    pulse_done();
    $display("test_simultaneous done");
  endtask

  task automatic test_mask();
    logic [31:0] d;
    apply_reset();
    cpu_ie = 1'b1;
    irq_in[0] = 1'b1;
    tick();
    irq_in = '0;
    repeat (3) tick();
    rd(2'd1, d);
    n_checks++;
    if (d !== 32'h01 || intreq !== 1'b0) begin
      n_fail++;
      $display("FAIL mask_blocked: pend=0x%0h intreq=%b, want 0x1 0", d, intreq);
    end
    wr(2'd0, 32'h01);
    n_checks++;
    if (intreq !== 1'b0) begin n_fail++; $display("FAIL mask_write_edge: intreq=%b want 0", intreq); end
    tick();
    n_checks++;
    if (intreq !== 1'b1) begin n_fail++; $display("FAIL mask_enabled: intreq=%b want 1", intreq); end
    $display("test_mask done");
  endtask

  task automatic test_w1c();
    logic [31:0] d;
    apply_reset();
    wr(2'd0, 32'h08);
    cpu_ie = 1'b1;
    irq_in[3] = 1'b1;
    tick();
    irq_in = '0;
    tick();
    wr(2'd1, 32'h08);
    n_checks++;
    if (intreq !== 1'b1) begin n_fail++; $display("FAIL w1c_still_req: intreq=%b want 1", intreq); end
    tick();
    rd(2'd3, d);
    n_checks++;
    if (intreq !== 1'b0 || d !== 32'd0) begin
      n_fail++;
      $display("FAIL w1c_withdraw: intreq=%b status=0x%0h, want 0 0x0", intreq, d);
    end
    irq_in[3] = 1'b1;
    tick();
    irq_in = '0;
    tick();
    // W1C and a new rising edge on the same bit in the same cycle
    irq_in[3] = 1'b1;
    wr(2'd1, 32'h08);
    irq_in = '0;
    rd(2'd1, d);
    n_checks++;
    if (d !== 32'h08) begin n_fail++; $display("FAIL w1c_set_wins: pend=0x%0h want 0x8", d); end
    tick();
    n_checks++;
    if (intreq !== 1'b1) begin n_fail++; $display("FAIL w1c_keep_req: intreq=%b want 1", intreq); end
    // Rising edge on the winner in the acknowledge cycle keeps it pending
    irq_in[3] = 1'b1;
    pulse_ack();
    irq_in = '0;
    rd(2'd1, d);
    n_checks++;
    if (irq_id !== 3'd3 || in_service !== 1'b1 || d !== 32'h08) begin
      n_fail++;
      $display("FAIL ack_set_wins: id=%0d insvc=%b pend=0x%0h, want 3 1 0x8", irq_id, in_service, d);
    end
    $display("test_w1c done");
  endtask

  task automatic test_no_nesting();
    logic [31:0] d;
    apply_reset();
    wr(2'd0, 32'h01);
    cpu_ie = 1'b1;
    irq_in[0] = 1'b1;
    tick();
    irq_in = '0;
    tick();
    pulse_done();
    n_checks++;
    if (intreq !== 1'b1 || in_service !== 1'b0) begin
      n_fail++;
      $display("FAIL nest_stray_done: intreq=%b insvc=%b, want 1 0", intreq, in_service);
    end
    pulse_ack();
    irq_in[0] = 1'b1;
    tick();
    irq_in = '0;
    repeat (3) tick();
    rd(2'd1, d);
    n_checks++;
    if (intreq !== 1'b0 || in_service !== 1'b1 || irq_id !== 3'd0 || d !== 32'h01) begin
      n_fail++;
      $display("FAIL nest_blocked: intreq=%b insvc=%b id=%0d pend=0x%0h, want 0 1 0 0x1", intreq, in_service, irq_id, d);
    end
    pulse_ack();
    rd(2'd3, d);
    n_checks++;
    if (in_service !== 1'b1 || d !== 32'h4) begin
      n_fail++;
      $display("FAIL nest_stray_ack_svc: insvc=%b status=0x%0h, want 1 0x4", in_service, d);
    end
    pulse_done();
    n_checks++;
    if (intreq !== 1'b0 || in_service !== 1'b0) begin
      n_fail++;
      $display("FAIL nest_done: intreq=%b insvc=%b, want 0 0", intreq, in_service);
    end
    tick();
    n_checks++;
    if (intreq !== 1'b1) begin n_fail++; $display("FAIL nest_rereq: intreq=%b want 1", intreq); end
    pulse_ack();
    n_checks++;
    if (irq_id !== 3'd0 || in_service !== 1'b1) begin
      n_fail++;
      $display("FAIL nest_second_ack: id=%0d insvc=%b, want 0 1", irq_id, in_service);
    end
    pulse_done();
    pulse_ack();
    rd(2'd3, d);
    n_checks++;
    if (d !== 32'd0 || in_service !== 1'b0) begin
      n_fail++;
      $display("FAIL nest_stray_ack_idle: status=0x%0h insvc=%b, want 0x0 0", d, in_service);
    end
    $display("test_no_nesting done");
  endtask

  task automatic test_async_reset();
    logic [31:0] dm, dp;
    apply_reset();
    wr(2'd0, 32'h3F);
    cpu_ie = 1'b1;
    irq_in = 6'b100010;
    tick();
    irq_in = '0;
    tick();
    #2;
    reset = 1'b0;
    #1;
    rd(2'd0, dm);
    rd(2'd1, dp);
    n_checks++;
    if (intreq !== 1'b0 || in_service !== 1'b0 || dm !== 32'd0 || dp !== 32'd0) begin
      n_fail++;
      $display("FAIL async_reset: intreq=%b insvc=%b mask=0x%0h pend=0x%0h, want all 0", intreq, in_service, dm, dp);
    end
    reset = 1'b1;
    tick();
    $display("test_async_reset done");
  endtask

  function automatic int lowest(input int v);
    for (int i = 0; i < N; i++) begin
      if (v[i]) return i;
    end
    return 0;
  endfunction

  // Randomized run against a model that tracks the spec's rules directly:
  // phase 0/1/2 = idle/requesting/in service, plus mask, pending and id.
  task automatic test_random();
    int m_mask, m_pend, m_phase, m_id, m_prev;
    int rise, reqv, ackclr, w1c, exp_reg, a;
    logic [31:0] d;
    apply_reset();
    m_mask = 0; m_pend = 0; m_phase = 0; m_id = 0; m_prev = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      irq_in    = 6'($urandom & $urandom);
      cpu_ie    = ($urandom % 4) != 0;
      int_ack   = (m_phase == 1) ? (($urandom % 3) == 0) : (($urandom % 10) == 0);
      int_done  = (m_phase == 2) ? (($urandom % 4) == 0) : (($urandom % 10) == 0);
      dev_we    = ($urandom % 5) == 0;
      dev_addr  = 2'($urandom);
      dev_wdata = $urandom;

      rise   = int'(irq_in) & ~m_prev & 'h3F;
      reqv   = m_pend & m_mask;
      ackclr = 0;
      case (m_phase)
        0: if (cpu_ie && reqv != 0) m_phase = 1;
        1: begin
          if (int_ack) begin
            m_id = lowest(reqv);
            if (reqv != 0) ackclr = 1 << m_id;
            m_phase = 2;
          end else if (reqv == 0) begin
            m_phase = 0;
          end
        end
        default: if (int_done) m_phase = 0;
      endcase
      w1c = (dev_we && dev_addr == 2'd1) ? int'(dev_wdata[5:0]) : 0;
      m_pend = ((m_pend & ~(w1c | ackclr)) | rise) & 'h3F;
      if (dev_we && dev_addr == 2'd0) m_mask = int'(dev_wdata[5:0]);
      m_prev = int'(irq_in);

      tick();
      dev_we = 1'b0; int_ack = 1'b0; int_done = 1'b0;

      n_checks++;
      if (intreq !== (m_phase == 1) || in_service !== (m_phase == 2)) begin
        n_fail++;
        $display("FAIL rand_outputs cyc %0d: intreq=%b insvc=%b, want phase %0d", cyc, intreq, in_service, m_phase);
      end
      if (m_phase == 2) begin
        n_checks++;
        if (int'(irq_id) != m_id) begin
          n_fail++;
          $display("FAIL rand_id cyc %0d: got %0d want %0d", cyc, irq_id, m_id);
        end
      end
      a = int'($urandom % 4);
      case (a)
        0: exp_reg = m_mask;
        1: exp_reg = m_pend;
        2: exp_reg = ((m_phase == 2) ? 8 : 0) | m_id;
        default: exp_reg = (m_phase << 1) | ((m_phase == 1) ? 1 : 0);
      endcase
      rd(2'(a), d);
      n_checks++;
      if (d !== 32'(exp_reg)) begin
        n_fail++;
        $display("FAIL rand_reg%0d cyc %0d: got 0x%0h want 0x%0h", a, cyc, d, exp_reg);
      end
    end
    $display("test_random done");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_simultaneous();
    test_mask();
    test_w1c();
    test_no_nesting();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
